// File: rtl/audio_pkg.sv
// audio_pkg: shared frame geometry and sample types
// for the Pocket I2S audio path.
package audio_pkg;

  localparam int I2S_FRAME_CYCLES = 256;
  localparam int I2S_BIT_CYCLES   = 4;
  localparam int I2S_SLOT_BITS    = 32;

  typedef struct packed {
    logic signed [15:0] l;
    logic signed [15:0] r;
  } stereo_sample_t;

endpackage

// File: rtl/sample_fifo2.sv
// sample_fifo2: two-entry synchronous FIFO with
// simultaneous push and pop.
module sample_fifo2
  import audio_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         do_push;
  logic         do_pop;

  assign full     = count == 2'd2;
  assign empty    = count == 2'd0;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers and occupancy; push+pop keeps count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= !wr_ptr;
      if (do_pop)  rd_ptr <= !rd_ptr;
      count <= count + 2'(do_push)
                     - 2'(do_pop);
    end
  end

  // Entry storage, cleared so stale pairs never leak.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: 48 kHz I2S transmitter from 12.288 MHz.
// Option AUDIO_I2S_TX_UNDERRUN_COUNT_EN adds underrun counter.
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int SAMPLE_WIDTH     = 16,
  parameter bit HOLD_ON_UNDERRUN = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SAMPLE_WIDTH-1:0] sample_l,
  input  logic [SAMPLE_WIDTH-1:0] sample_r,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  input  logic                    mute,
  output logic                    frame_start,
  output logic                    underrun,
  output logic [15:0]             underrun_count,
  output logic                    sclk,
  output logic                    lrck,
  output logic                    dac
);

  localparam int SW  = SAMPLE_WIDTH;
  localparam int CW  = $clog2(I2S_FRAME_CYCLES);
  localparam int PAD = I2S_SLOT_BITS - 1 - SW;

  logic [CW-1:0]            frame_cnt;
  logic                     load;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [2*SW-1:0]          head;
  logic [SW-1:0]            cur_l;
  logic [SW-1:0]            cur_r;
  logic                     mute_q;
  logic [SW-1:0]            word;
  logic [I2S_SLOT_BITS-1:0] slot;
  logic [4:0]               bit_idx;
  logic                     dac_bit;

  assign load         = frame_cnt == CW'(I2S_FRAME_CYCLES - 1);
  assign sample_ready = !fifo_full;

  sample_fifo2 #(
    .W (2 * SW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (sample_valid),
    .push_data ({sample_l, sample_r}),
    .pop       (load),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Slot bit 0 is the I2S delay bit; sample MSB
  // follows, then zero padding to 32 bits.
  assign bit_idx = frame_cnt[6:2];
  assign word    = frame_cnt[7] ? cur_r : cur_l;
  assign slot    = I2S_SLOT_BITS'(word) << PAD;
  assign dac_bit = slot[~bit_idx];

  // Free-running frame position.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_cnt <= '0;
    else       frame_cnt <= frame_cnt + 1'b1;
  end

  // Load the next frame (or hold/clear on underrun).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_l <= '0;
      cur_r <= '0;
    end else if (load) begin
      if (!fifo_empty) begin
        {cur_l, cur_r} <= head;
      end else if (!HOLD_ON_UNDERRUN) begin
        cur_l <= '0;
        cur_r <= '0;
      end
    end
  end

  // Frame pulses; mute only changes on word boundaries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      mute_q      <= 1'b0;
    end else begin
      frame_start <= load;
      underrun    <= load && fifo_empty;
      if (load) mute_q <= mute;
    end
  end

  // Registered serial outputs, one cycle behind count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk <= 1'b0;
      lrck <= 1'b0;
      dac  <= 1'b0;
    end else begin
      sclk <= frame_cnt[1];
      lrck <= frame_cnt[7];
      dac  <= dac_bit && !mute_q;
    end
  end

`ifdef AUDIO_I2S_TX_UNDERRUN_COUNT_EN
  logic [15:0] urun_cnt;

  // Saturating underrun count, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      urun_cnt <= '0;
    end else if (underrun && urun_cnt != 16'hFFFF) begin
      urun_cnt <= urun_cnt + 16'd1;
    end
  end

  assign underrun_count = urun_cnt;
`else
  assign underrun_count = '0;
`endif

endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb_audio_i2s_tx: scoreboard bench for audio_i2s_tx.
// Stimulus queues expected frames; monitor checks dac.
module tb_audio_i2s_tx;
  import audio_pkg::*;

  typedef struct {
    logic [31:0] wl;
    logic [31:0] wr;
    logic        uf;
  } frame_exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] sample_l = '0;
  logic [15:0] sample_r = '0;
  logic        sample_valid = 1'b0;
  logic        mute = 1'b0;
  logic        sample_ready;
  logic        frame_start;
  logic        underrun;
  logic [15:0] underrun_count;
  logic        sclk;
  logic        lrck;
  logic        dac;

  int checks = 0;
  int failures = 0;

  frame_exp_t     eq[$];
  stereo_sample_t mq[$];
  stereo_sample_t cur = '0;
  int   pos = 0;
  int   fidx = 0;
  int   n = 0;
  int   acc_frame = 0;
  logic pend = 1'b0;
  logic mon_stop = 1'b0;
  logic mon_done = 1'b0;

  logic [15:0] tbl_l [8] = '{16'h0001, 16'hFFFF,
    16'h1357, 16'hC0DE, 16'h7FFF, 16'h8000,
    16'h0F0F, 16'hF0F0};
  logic [15:0] tbl_r [8] = '{16'hA5A5, 16'h0002,
    16'h2468, 16'hBEEF, 16'h8000, 16'h7FFF,
    16'h3C3C, 16'hC3C3};

  audio_i2s_tx dut (
    .clk            (clk),
    .reset          (reset),
    .sample_l       (sample_l),
    .sample_r       (sample_r),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .mute           (mute),
    .frame_start    (frame_start),
    .underrun       (underrun),
    .underrun_count (underrun_count),
    .sclk           (sclk),
    .lrck           (lrck),
    .dac            (dac)
  );

  always #5 clk = !clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s timeout", nm);
  endtask

  function automatic logic [31:0] slot_of(
    input logic [15:0] s, input logic m);
    return m ? 32'h0 : {1'b0, s, 15'h0};
  endfunction

  // One stimulus cycle: model frame loads and accepts,
  // then drive inputs for the next edge.
  task automatic step();
    frame_exp_t e;
    @(negedge clk);
    pos++;
    if (frame_start) begin
      pos = 0;
      fidx++;
      if (fidx >= 6 && fidx <= 10)
        chk("accepts_per_frame", 64'(acc_frame),
            (fidx == 6) ? 64'd2 : 64'd1);
      acc_frame = 0;
      e.uf = (mq.size() == 0);
      if (!e.uf) cur = mq.pop_front();
      e.wl = slot_of(cur.l, mute);
      e.wr = slot_of(cur.r, mute);
      eq.push_back(e);
      if (fidx == 5) n = 0;
      if (fidx == 13) mon_stop = 1'b1;
    end
    if (pend) begin
      mq.push_back({sample_l, sample_r});
      n++;
      acc_frame++;
    end
    sample_valid = 1'b0;
    if (fidx == 0 && pos == 1)
      chk("ready_after_reset", 64'(sample_ready), 64'd1);
    if (fidx == 3 && pos == 10) begin
      sample_l = 16'h8001;
      sample_r = 16'h7FFE;
      sample_valid = 1'b1;
    end
    if (fidx == 4 && pos == 0) begin
`ifdef AUDIO_I2S_TX_UNDERRUN_COUNT_EN
      chk("underrun_count", 64'(underrun_count), 64'd3);
`else
      chk("underrun_count", 64'(underrun_count), 64'd0);
`endif
    end
    if (fidx >= 5 && fidx <= 9) begin
      sample_l = tbl_l[n];
      sample_r = tbl_r[n];
      sample_valid = 1'b1;
    end
    if (fidx == 5 && pos == 5) begin
      chk("ready_drop", 64'(sample_ready), 64'd0);
      chk("fill_accepts", 64'(acc_frame), 64'd2);
    end
    if (fidx == 11 && pos == 100) mute = 1'b1;
    if (fidx == 12 && pos == 100) mute = 1'b0;
    pend = sample_valid && sample_ready;
  endtask

  // Monitor: capture each frame from dac, compare
  // against the oldest queued expectation.
  initial begin : monitor
    frame_exp_t  e;
    logic [31:0] wl;
    logic [31:0] wr;
    logic [7:0]  f;
    logic        uf;
    int          unst;
    int          tbad;
    int          to;
    @(negedge reset);
    forever begin
      to = 0;
      do begin
        @(negedge clk);
        to++;
      end while (!frame_start && to < 600);
      if (!frame_start) begin
        timeout("mon_frame_start");
        break;
      end
      uf = underrun;
      wl = '0;
      wr = '0;
      unst = 0;
      tbad = 0;
      for (int j = 1; j < 256; j++) begin
        @(negedge clk);
        f = 8'(j - 1);
        if (lrck !== f[7] || sclk !== f[1]) tbad++;
        if (f[1:0] == 2'd0) begin
          if (f[7]) wr[~f[6:2]] = dac;
          else      wl[~f[6:2]] = dac;
        end else if (dac !== (f[7] ? wr[~f[6:2]]
                                   : wl[~f[6:2]])) begin
          unst++;
        end
      end
      if (eq.size() == 0) begin
        timeout("scoreboard_empty");
      end else begin
        e = eq.pop_front();
        chk("left_slot", 64'(wl), 64'(e.wl));
        chk("right_slot", 64'(wr), 64'(e.wr));
        chk("underrun_pulse", 64'(uf), 64'(e.uf));
        chk("sclk_lrck_timing", 64'(tbad), 64'd0);
        chk("bit_stability", 64'(unst), 64'd0);
      end
      if (mon_stop) break;
    end
    mon_done = 1'b1;
  end

  initial begin : stimulus
    int guard;
    int k;
    int ones;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        64'({sclk, lrck, dac, frame_start, underrun}),
        64'd0);
    chk("reset_underrun_count",
        64'(underrun_count), 64'd0);
    reset = 1'b0;
    guard = 0;
    while (!mon_done && guard < 5000) begin
      step();
      guard++;
    end
    if (!mon_done) timeout("main_frames");

    @(negedge clk);
    sample_l = 16'h1234;
    sample_r = 16'h4321;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_l = 16'hAAAA;
    sample_r = 16'h5555;
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (58) @(negedge clk);
    chk("two_queued_full", 64'(sample_ready), 64'd0);
    reset = 1'b1;
    #1;
    chk("async_reset_outputs",
        64'({sclk, lrck, dac, frame_start, underrun}),
        64'd0);
    chk("async_reset_ready", 64'(sample_ready), 64'd1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1)
        chk("ready_after_rerelease",
            64'(sample_ready), 64'd1);
    end while (!underrun && k < 300);
    chk("first_underrun_cycle", 64'(k), 64'd256);
    ones = 0;
    for (int j = 0; j < 256; j++) begin
      @(negedge clk);
      if (dac !== 1'b0) ones++;
    end
    chk("dac_zero_after_reset", 64'(ones), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/audio_i2s_tx.md
# audio_i2s_tx

Standalone I2S transmitter for the Pocket audio path. It accepts signed 16-bit stereo samples over a valid/ready handshake and buffers them in a 2-entry FIFO. It serialises them at 48 kHz into the `audio_if` signals (`lrck`, `dac`, plus a bit clock) from the 12.288 MHz audio clock. It sits directly downstream of the core's sample CDC and replaces ad-hoc shifter logic in each core top.

## Interface
Parameters:
- `SAMPLE_WIDTH`, default 16: width of each channel sample; must be ≤ 31.
- `HOLD_ON_UNDERRUN`, default 1: 1 = repeat the last frame on underrun; 0 = send zeros.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in, 1: 12.288 MHz audio clock; also drives `audio.mclk` at the core top.
- `reset` in, 1: async active-high reset.
- `sample_l` in, `SAMPLE_WIDTH`: left sample, signed two's complement.
- `sample_r` in, `SAMPLE_WIDTH`: right sample.
- `sample_valid` in, 1: producer offers `{sample_l, sample_r}`.
- `sample_ready` out, 1: FIFO can accept a sample pair.
- `mute` in, 1: force `dac` to 0; timing is unaffected.
- `frame_start` out, 1: one-cycle pulse when a frame is loaded from the FIFO.
- `underrun` out, 1: one-cycle pulse when a frame load finds the FIFO empty.
- `underrun_count` out, 16: saturating underrun count (see Configuration).
- `sclk` out, 1: bit clock, 3.072 MHz.
- `lrck` out, 1: word select; 0 = left, 1 = right.
- `dac` out, 1: serial data.

## Operation
- `frame_cnt` is an 8-bit free-running counter over 0..255; one frame is 256 `clk` cycles (48 kHz).
- Each bit lasts 4 cycles. Slot bit index `b = frame_cnt[6:2]`; channel = `frame_cnt[7]`.
- Each channel slot is 32 bits in standard I2S format:
  - `b = 0`: 0 (one-bit delay after the LRCK edge).
  - `b = 1..SAMPLE_WIDTH`: sample bits MSB first.
  - Remaining bits: 0.
- The registered outputs are computed from `frame_cnt`:
  - `sclk = frame_cnt[1]`
  - `lrck = frame_cnt[7]`
  - `dac` = the selected bit, ANDed with `!mute_q`.
- `dac` therefore changes only as `sclk` goes low.
- FIFO:
  - 2 entries of `{l, r}`.
  - Push when `sample_valid && sample_ready`; `sample_ready = !full`.
  - Pop at `frame_cnt == 255` if not empty.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
- Frame load at `frame_cnt == 255`:
  - Non-empty FIFO: the head moves into `cur_l`/`cur_r`, and `frame_start` pulses.
  - Empty FIFO: `cur_l`/`cur_r` hold their value (or clear when `HOLD_ON_UNDERRUN = 0`), and `underrun` pulses. `frame_start` still pulses.
- `mute` is sampled into `mute_q` only at `frame_cnt == 255`, so muting never truncates a word.

## Timing
- Reset values: `frame_cnt = 0`, FIFO empty, `cur_l = cur_r = 0`, and `sclk`, `lrck`, `dac`, `frame_start`, `underrun` all 0. `underrun_count = 0`; `sample_ready = 1` from the first cycle after reset deasserts.
- Serial outputs lag `frame_cnt` by exactly 1 cycle.
- Latency from an accepted sample to its first MSB on `dac`, with the FIFO empty and the push landing at `frame_cnt = k`:
  - Load happens at the next `frame_cnt = 255`.
  - The MSB appears on `dac` from the cycle after `frame_cnt = 4`.
  - Worst case is 261 cycles.
- Reset asserted mid-frame takes effect immediately: all outputs go to 0 and the FIFO contents are discarded. The first frame after release starts at `frame_cnt = 0` with zero samples.
- `sample_ready` depends only on registered occupancy; there is no combinational path from `sample_valid`.

## Configuration
- `AUDIO_I2S_TX_UNDERRUN_COUNT_EN` defined:
  - `underrun_count` increments on each `underrun` pulse and saturates at 16'hFFFF.
  - It is cleared only by `reset`.
- Not defined: `underrun_count` is tied to 0 and the counter logic is not synthesised.

## Structure
- Package `audio_pkg`:
  - `localparam I2S_FRAME_CYCLES = 256`, `I2S_BIT_CYCLES = 4`, `I2S_SLOT_BITS = 32`.
  - `typedef struct packed { logic signed [15:0] l, r; } stereo_sample_t`.
- One sub-module, `sample_fifo2`: a 2-entry synchronous FIFO with push/pop/full/empty and simultaneous push+pop support.

## Test plan
- Reset release, no samples pushed:
  - `sclk` toggles with period 4 cycles and `lrck` with period 256.
  - `dac` stays 0.
  - `underrun` pulses every 256 cycles.
- Push L=16'h8001, R=16'h7FFE once:
  - Left slot serialises 0, 1, 0×14, 1, then 15 zeros.
  - Right slot serialises 0, 0, 1×14, 0, then 15 zeros.
  - Each bit is stable for 4 cycles.
- Hold `sample_valid` high continuously:
  - After 2 accepts, `sample_ready` drops.
  - One pop occurs per frame; exactly 1 accept follows each `frame_start`, and no sample is lost or duplicated.
- Assert `mute` at `frame_cnt = 100`:
  - The current frame completes unmuted.
  - `dac` is 0 from the next frame; `lrck`/`sclk` are unchanged.
- Assert `reset` at `frame_cnt = 60` with 2 samples queued:
  - Outputs go to 0 asynchronously.
  - After release, the FIFO is empty and the first `underrun` occurs at the first `frame_cnt = 255`.
- With `AUDIO_I2S_TX_UNDERRUN_COUNT_EN`, run 3 empty frames, then 1 fed frame:
  - `underrun_count = 3`.
  - Without the macro, it reads 0.
